// File: rtl/grf_wdecode_if.sv
// -----------------------------------------------------------------------------
// grf_wdecode_if
// Bus bundle for the grf_wdecode register file: both read ports, the
// write-back port, the trace PC and the committed-write counter.
//   master : the pipeline side. It drives the addresses, write enable/data and
//            the PC, and receives the read data and wcnt.
//   slave  : the register file side.
// Ports (all of them interface signals):
//   a1, a2   5b   read addresses (rs, rt)
//   rd1, rd2 DW   read data
//   we       1b   write enable from WB
//   a3       5b   write address from WB
//   wd       DW   write data from WB
//   wpc      32b  PC of the writing instruction (trace only)
//   wcnt     16b  committed register writes since reset
// -----------------------------------------------------------------------------
interface grf_wdecode_if #(
    parameter int DW = 32
);
    logic [4:0]    a1;
    logic [4:0]    a2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          we;
    logic [4:0]    a3;
    logic [DW-1:0] wd;
    logic [31:0]   wpc;
    logic [15:0]   wcnt;

    modport master (
        output a1, a2, we, a3, wd, wpc,
        input  rd1, rd2, wcnt
    );

    modport slave (
        input  a1, a2, we, a3, wd, wpc,
        output rd1, rd2, wcnt
    );
endinterface

// File: rtl/grf_wdecode.sv
// -----------------------------------------------------------------------------
// grf_wdecode
// A 32 x DW general register file for the P6 pipelined MIPS core. One WB write
// stream is decoded by a3 onto a single register. There are two combinational
// read ports with an internal write-to-read bypass, so the ID stage sees a WB
// result in the same cycle it is written. Register 0 is hard-wired to zero.
//
// Ports:
//   clk    system clock; every state update happens on the rising edge
//   reset  synchronous, active-high; clears all registers and wcnt, and takes
//          priority over a write in the same cycle
//   bus    grf_wdecode_if.slave (a1/a2/rd1/rd2, we/a3/wd, wpc, wcnt)
//
// Build option:
//   GRF_DISPLAY_EN  when defined, every committed write prints
//                   "@<wpc>: $<a3> <= <wd>" to match the course reference
//                   simulator trace. When undefined, wpc is unused and the
//                   function is unchanged.
// -----------------------------------------------------------------------------
module grf_wdecode #(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    grf_wdecode_if.slave  bus
);
    logic [DW-1:0] regs [NREG];
    logic [15:0]   wcnt_q;
    logic          commit;

    // A write counts only when it targets a real register. Writes to $0 are
    // discarded without touching the counter.
    assign commit = bus.we && (bus.a3 != 5'd0);

    // NOTE: the array is cleared on reset on purpose. The core relies on every
    // register reading 0 after reset, so this is not a RAM macro that can
    // skip initialisation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wcnt_q <= '0;
        end else if (commit) begin
            regs[bus.a3] <= bus.wd;
            wcnt_q       <= wcnt_q + 16'd1;   // wraps FFFF -> 0000
        end
    end

    // Read ports. $0 always reads 0. A write to the same address in this cycle
    // is forwarded ahead of the stored value. The bypass ignores reset,
    // because reset only takes effect at the edge.
    // NOTE: each output gets its default first, so every path assigns it and
    // no latch can be inferred.
    always_comb begin
        bus.rd1 = '0;
        if (bus.a1 != 5'd0) begin
            if (bus.we && (bus.a3 == bus.a1)) begin
                bus.rd1 = bus.wd;
            end else begin
                bus.rd1 = regs[bus.a1];
            end
        end
    end

    always_comb begin
        bus.rd2 = '0;
        if (bus.a2 != 5'd0) begin
            if (bus.we && (bus.a3 == bus.a2)) begin
                bus.rd2 = bus.wd;
            end else begin
                bus.rd2 = regs[bus.a2];
            end
        end
    end

    assign bus.wcnt = wcnt_q;

`ifdef GRF_DISPLAY_EN
    // The trace line is printed at the edge where the write commits.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            $display("@%h: $%d <= %h", bus.wpc, bus.a3, bus.wd);
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^bus.wpc;
`endif

endmodule

// File: tb/tb_grf_wdecode.sv
// -----------------------------------------------------------------------------
// tb_grf_wdecode
// Directed stimulus for grf_wdecode. A behavioural register-file model sits
// alongside the DUT. On every falling edge after the first reset, one compare
// process checks rd1, rd2 and wcnt against that model. Hand-computed literal
// checks at the key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_grf_wdecode;
    logic clk = 1'b0;
    logic reset;

    grf_wdecode_if #(.DW(32)) bus ();

    grf_wdecode #(.NREG(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem [32];
    int unsigned n_writes;
    bit          cmp_en = 1'b0;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.we === 1'b1 && bus.a3 == a) return bus.wd;
        return mem[a];
    endfunction

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            foreach (mem[i]) mem[i] = 32'd0;
            n_writes = 0;
        end else if (bus.we === 1'b1 && bus.a3 != 5'd0) begin
            mem[bus.a3] = bus.wd;
            n_writes    = n_writes + 1;
        end
    end

    // One compare process: inputs and state are stable at the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp rd1",  bus.rd1,  model_read(bus.a1));
            check("cmp rd2",  bus.rd2,  model_read(bus.a2));
            check("cmp wcnt", {16'd0, bus.wcnt}, n_writes % 65536);
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change just after the falling edge, once the compare has sampled.
    task automatic step(input logic r, input logic w, input logic [4:0] a3,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        #1;
        reset   = r;
        bus.we  = w;
        bus.a3  = a3;
        bus.wd  = wd;
        bus.a1  = a1;
        bus.a2  = a2;
        bus.wpc = 32'h0000_3000 + {25'd0, a3, 2'b00};
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; bus.we = 1'b0; bus.a3 = '0; bus.wd = '0;
        bus.a1 = '0; bus.a2 = '0; bus.wpc = '0;
        @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;

        // Reset then read: every address reads 0.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            check("sweep rd1", bus.rd1, 32'd0);
            check("sweep rd2", bus.rd2, 32'd0);
        end
        check("sweep wcnt", {16'd0, bus.wcnt}, 32'd0);

        // Basic write and read.
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6);
        check("basic rd1", bus.rd1, 32'hDEADBEEF);
        check("basic rd2", bus.rd2, 32'd0);
        check("basic wcnt", {16'd0, bus.wcnt}, 32'd1);

        // Zero register: no bypass, no store, no count.
        step(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
        check("zero during rd1", bus.rd1, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
        check("zero after rd1", bus.rd1, 32'd0);
        check("zero after wcnt", {16'd0, bus.wcnt}, 32'd1);

        // Same-cycle bypass on both ports.
        step(1'b0, 1'b1, 5'd7, 32'd1, 5'd0, 5'd0);
        step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7);
        check("bypass rd1", bus.rd1, 32'hA5A5A5A5);
        check("bypass rd2", bus.rd2, 32'hA5A5A5A5);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd5);
        check("bypass after rd1", bus.rd1, 32'hA5A5A5A5);
        check("bypass after rd2", bus.rd2, 32'hDEADBEEF);
        check("bypass wcnt", {16'd0, bus.wcnt}, 32'd3);

        // Mixed traffic: a write to one port's address, the other port reads
        // stored data.
        step(1'b0, 1'b1, 5'd31, 32'h0BAD_F00D, 5'd31, 5'd7);
        check("mixed rd1", bus.rd1, 32'h0BAD_F00D);
        check("mixed rd2", bus.rd2, 32'hA5A5A5A5);
        step(1'b0, 1'b1, 5'd9, 32'd3, 5'd31, 5'd9);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd31);
        check("reg9 rd1", bus.rd1, 32'd3);
        check("reg9 wcnt", {16'd0, bus.wcnt}, 32'd5);

        // Reset vs write collision. The read still bypasses before the edge.
        step(1'b1, 1'b1, 5'd9, 32'hFFFF0000, 5'd9, 5'd31);
        check("collide during rd1", bus.rd1, 32'hFFFF0000);
        check("collide during rd2", bus.rd2, 32'h0BAD_F00D);
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd31);
        check("collide after rd1", bus.rd1, 32'd0);
        check("collide after rd2", bus.rd2, 32'd0);
        check("collide wcnt", {16'd0, bus.wcnt}, 32'd0);

        // Counter wrap: 65537 writes to $1 with incrementing data.
        for (int i = 0; i < 65537; i++) begin
            step(1'b0, 1'b1, 5'd1, 32'(i), 5'd2, 5'd1);
            if (i == 65535) check("wcnt at FFFF", {16'd0, bus.wcnt}, 32'h0000_FFFF);
        end
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd0);
        check("wrap rd1", bus.rd1, 32'd65536);
        check("wrap wcnt", {16'd0, bus.wcnt}, 32'd1);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/grf_wdecode.md
Name: grf_wdecode

Overview:
- 32 x 32-bit general register file for the P6 pipelined MIPS core.
- The write port is the other end of the datapath selectors: one write-back stream is decoded by a 5-bit address onto one of 32 registers.
- Two asynchronous read ports with internal write-to-read bypass, so the ID stage sees a same-cycle WB result without an external forwarding select.
- Sits between the WB stage (write side) and the ID stage (read side).

Parameters:
- NREG, 32, number of registers; address width is fixed at 5.
- DW, 32, data width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a1  input  5  read port 1 address (rs).
- a2  input  5  read port 2 address (rt).
- rd1  output  32  read port 1 data.
- rd2  output  32  read port 2 data.
- we  input  1  write enable from WB.
- a3  input  5  write address from WB (rd/rt/31 already selected upstream).
- wd  input  32  write data from WB.
- wpc  input  32  PC of the writing instruction; used only by the optional feature.
- wcnt  output  16  count of committed register writes since reset.

Behaviour:
- Storage: 32 registers reg[0..31], each DW bits.
- Reset: one clock with reset=1 at a rising edge sets every reg to 0 and wcnt to 0. Reset has priority over we in the same cycle.
- Write decode: at a rising edge with reset=0, we=1 and a3!=0, reg[a3] <= wd and wcnt <= wcnt+1. Exactly one register changes.
- Writes with a3==0 are dropped: reg[0] stays 0 and wcnt is not incremented. we=0 changes nothing.
- wcnt wraps from 16'hFFFF to 16'h0000 with no saturation.
- Read ports are combinational, with zero-cycle latency from a1/a2.
- rd1 = 0 if a1==0.
- Otherwise rd1 = wd if we==1 and a3==a1 (bypass); otherwise rd1 = reg[a1].
- rd2 follows the same rule using a2.
- Both ports may read the same address simultaneously; both may bypass in the same cycle.
- Bypass never applies to address 0, even if we=1 and a3=0.
- While reset=1, rd1 and rd2 still follow the rule above: they show the pre-reset contents until the reset edge, then 0.
- Reset asserted in the same cycle as a write: the write is lost and all regs read 0 after the edge.
- No X propagation: all outputs are defined from the first reset edge onward.

Optional Feature:
- Macro: GRF_DISPLAY_EN.
- Defined: on every committed write (the same condition that increments wcnt), the block prints a line in the form "@<wpc 8 hex>: $<a3 2 dec> <= <wd 8 hex>" at that clock edge. This is for comparison against the course reference simulator.
- Dropped writes (a3==0) and cycles with reset=1 print nothing.
- Not defined: no print statements are compiled; wpc is unused; functional behaviour is identical.

Test Plan:
- Reset then read: assert reset 1 cycle, then sweep a1/a2 over 0..31 -> rd1=rd2=0 for all, wcnt=0.
- Basic write/read: we=1, a3=5, wd=32'hDEADBEEF for one edge, then we=0 and a1=5 -> rd1=32'hDEADBEEF, wcnt=1.
- Zero register: we=1, a3=0, wd=32'h12345678 for one edge; a1=0 both during and after -> rd1=0 throughout, wcnt unchanged.
- Same-cycle bypass: reg[7]=1 beforehand; drive we=1, a3=7, wd=32'hA5A5A5A5 with a1=a2=7 before the edge -> rd1=rd2=32'hA5A5A5A5 combinationally. After the edge, with we=0 -> still 32'hA5A5A5A5.
- Reset vs write collision: reg[9]=3; reset=1 together with we=1, a3=9, wd=32'hFFFF0000 -> after the edge reg[9]=0 and wcnt=0.
- Counter wrap and display: perform 65537 writes to a3=1 with incrementing wd -> wcnt=1 and reg[1]=last wd. With GRF_DISPLAY_EN, spot-check a printed line such as "@00003000: $ 1 <= 00000000".
